// File: rtl/bus_scheduler.sv
// bus_scheduler: shared RAM/ROM time-slicing between the 6502 and the SPI loader.
// One phase counter per period of N = 2^(SPEED+1) clocks. The first half of
// the period belongs to SPI (service at phase 1, completion at phase 2) and the
// second half to the CPU (RAM write at the last phase).
module bus_scheduler #(
  parameter int SPEED = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic        cpu_rnw_i,
  input  logic        stall_i,
  output logic        cpu_enable_o,
  output logic        tia_enable_o,
  output logic        cpu_phi_o,
  output logic        cpu_rdy_o,
  output logic        cpu_reset_o,
  output logic [6:0]  ram_addr_o,
  output logic [7:0]  ram_din_o,
  output logic        ram_we_o,
  input  logic [7:0]  ram_dout_i,
  output logic [11:0] rom_addr_o,
  output logic [7:0]  rom_din_o,
  output logic        rom_we_o,
  input  logic        spi_wr_i,
  input  logic        spi_rd_i,
  input  logic [31:0] spi_addr_i,
  input  logic [7:0]  spi_data_i,
  output logic [7:0]  spi_data_o,
  output logic        spi_ack_o,
  output logic        spi_ovf_o,
  output logic [7:0]  ctrl_o
);

  localparam int PW = SPEED + 1;
  localparam logic [PW-1:0] PH_SVC  = PW'(1);
  localparam logic [PW-1:0] PH_LAST = {PW{1'b1}};

  logic [PW-1:0] phase;
  logic [7:0]    ctrl;

  // one-entry SPI request buffer
  logic          buf_valid;
  logic          buf_wr;
  logic [31:0]   buf_addr;
  logic [7:0]    buf_data;

  // completion-side state, live during the phase-2 cycle
  logic          ack_q;
  logic          rd_pend;
  logic          rd_ram_pend;
  logic [7:0]    rd_val_q;
  logic [7:0]    rdata_q;
  logic          ovf_q;

  logic          svc_now;
  logic          sel_rom;
  logic          sel_ram;
  logic          sel_ctrl;
  logic          strobe;
  logic          accept;
  logic          drop;
  logic          cpu_ram_we;
  logic          spi_ram_we;
  logic [7:0]    rd_value;
  logic          unused_bits;

  assign unused_bits = ^{cpu_addr_i[15:13], cpu_addr_i[11:10], cpu_addr_i[8],
                         buf_addr[23:12]};

  assign svc_now  = buf_valid && (phase == PH_SVC) && !rst_i;
  assign sel_rom  = (buf_addr[31:24] == 8'h00);
  assign sel_ram  = (buf_addr[31:24] == 8'h01);
  assign sel_ctrl = (buf_addr[31:24] == 8'hFF);

  // a strobe may refill the buffer in the very cycle it is being serviced
  assign strobe = spi_wr_i || spi_rd_i;
  assign accept = strobe && (!buf_valid || svc_now);
  assign drop   = strobe && buf_valid && !svc_now;

  assign cpu_enable_o = (phase == '0);
  assign tia_enable_o = (phase < PW'(3));
  assign cpu_phi_o    = phase[PW-1];
  assign cpu_rdy_o    = !stall_i && !ctrl[1];
  assign cpu_reset_o  = ctrl[0];
  assign ctrl_o       = ctrl;

  // CPU and SPI RAM writes live in disjoint phases, so they can never collide
  assign cpu_ram_we = (phase == PH_LAST) && !cpu_rnw_i && cpu_rdy_o && !rst_i &&
                      !cpu_addr_i[12] && !cpu_addr_i[9] && cpu_addr_i[7];
  assign spi_ram_we = svc_now && buf_wr && sel_ram;

  assign ram_we_o   = cpu_ram_we || spi_ram_we;
  assign ram_addr_o = svc_now ? buf_addr[6:0] : cpu_addr_i[6:0];
  assign ram_din_o  = svc_now ? buf_data : cpu_dout_i;

  assign rom_we_o   = svc_now && buf_wr && sel_rom;
  assign rom_addr_o = buf_addr[11:0];
  assign rom_din_o  = buf_data;

  // RAM read data only arrives in the ack cycle, so pass it straight through then
  assign rd_value   = rd_ram_pend ? ram_dout_i : rd_val_q;
  assign spi_data_o = rd_pend ? rd_value : rdata_q;
  assign spi_ack_o  = ack_q;
  assign spi_ovf_o  = ovf_q;

  // phase counter, request buffer, service bookkeeping and control register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase       <= '0;
      ctrl        <= 8'h00;
      buf_valid   <= 1'b0;
      buf_wr      <= 1'b0;
      buf_addr    <= 32'h0;
      buf_data    <= 8'h00;
      ack_q       <= 1'b0;
      rd_pend     <= 1'b0;
      rd_ram_pend <= 1'b0;
      rd_val_q    <= 8'h00;
      rdata_q     <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      phase       <= phase + PW'(1);
      ack_q       <= svc_now;
      rd_pend     <= svc_now && !buf_wr;
      rd_ram_pend <= svc_now && !buf_wr && sel_ram;
      if (svc_now) begin
        rd_val_q <= sel_ctrl ? ctrl : 8'h00;
      end
      if (svc_now && buf_wr && sel_ctrl) begin
        ctrl <= buf_data;
      end
      if (rd_pend) begin
        rdata_q <= rd_value;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (accept) begin
        buf_valid <= 1'b1;
        buf_wr    <= spi_wr_i;
        buf_addr  <= spi_addr_i;
        buf_data  <= spi_data_i;
      end else if (svc_now) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed bench for bus_scheduler (SPEED=3, period 16) with a registered RAM model.
module tb_bus_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] cpu_addr_i;
  logic [7:0]  cpu_dout_i;
  logic        cpu_rnw_i;
  logic        stall_i;
  logic        cpu_enable_o, tia_enable_o, cpu_phi_o, cpu_rdy_o, cpu_reset_o;
  logic [6:0]  ram_addr_o;
  logic [7:0]  ram_din_o;
  logic        ram_we_o;
  logic [7:0]  ram_dout_i;
  logic [11:0] rom_addr_o;
  logic [7:0]  rom_din_o;
  logic        rom_we_o;
  logic        spi_wr_i, spi_rd_i;
  logic [31:0] spi_addr_i;
  logic [7:0]  spi_data_i;
  logic [7:0]  spi_data_o;
  logic        spi_ack_o, spi_ovf_o;
  logic [7:0]  ctrl_o;

  int vectors = 0;
  int miscompares = 0;
  int ph = 0;
  int cnt;
  logic [7:0] mem [128];

  bus_scheduler #(.SPEED(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_addr_i(cpu_addr_i), .cpu_dout_i(cpu_dout_i), .cpu_rnw_i(cpu_rnw_i),
    .stall_i(stall_i),
    .cpu_enable_o(cpu_enable_o), .tia_enable_o(tia_enable_o), .cpu_phi_o(cpu_phi_o),
    .cpu_rdy_o(cpu_rdy_o), .cpu_reset_o(cpu_reset_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_we_o(ram_we_o),
    .ram_dout_i(ram_dout_i),
    .rom_addr_o(rom_addr_o), .rom_din_o(rom_din_o), .rom_we_o(rom_we_o),
    .spi_wr_i(spi_wr_i), .spi_rd_i(spi_rd_i), .spi_addr_i(spi_addr_i),
    .spi_data_i(spi_data_i), .spi_data_o(spi_data_o),
    .spi_ack_o(spi_ack_o), .spi_ovf_o(spi_ovf_o), .ctrl_o(ctrl_o)
  );

  always #5 clk_i = ~clk_i;

  // registered single-port RAM, read-before-write
  always @(posedge clk_i) begin
    if (ram_we_o) mem[ram_addr_o] <= ram_din_o;
    ram_dout_i <= mem[ram_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    ph = (ph + 1) % 16;
  endtask

  task automatic go_phase(input int p);
    while (ph != p) step();
  endtask

  task automatic spi_req(input logic wr, input logic [31:0] a, input logic [7:0] d);
    spi_wr_i   = wr;
    spi_rd_i   = !wr;
    spi_addr_i = a;
    spi_data_i = d;
  endtask

  task automatic spi_idle();
    spi_wr_i = 1'b0;
    spi_rd_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    cpu_addr_i = 16'h0000; cpu_dout_i = 8'h00; cpu_rnw_i = 1'b1; stall_i = 1'b0;
    spi_wr_i = 1'b0; spi_rd_i = 1'b0; spi_addr_i = 32'h0; spi_data_i = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    ph = 0;

    // reset state
    chk("rst_cpu_en", cpu_enable_o, 1);
    chk("rst_tia_en", tia_enable_o, 1);
    chk("rst_phi", cpu_phi_o, 0);
    chk("rst_ctrl", ctrl_o, 8'h00);
    chk("rst_ack", spi_ack_o, 0);
    chk("rst_ovf", spi_ovf_o, 0);
    chk("rst_sdata", spi_data_o, 8'h00);
    chk("rst_ram_we", ram_we_o, 0);
    chk("rst_rom_we", rom_we_o, 0);
    chk("rst_rdy", cpu_rdy_o, 1);

    // enables over one full period
    for (int i = 0; i < 16; i++) begin
      chk("cpu_en", cpu_enable_o, (ph == 0));
      chk("tia_en", tia_enable_o, (ph < 3));
      chk("phi", cpu_phi_o, (ph >= 8));
      step();
    end

    // SPI RAM write 0x01000005 <- A5, then read it back
    go_phase(0);
    spi_req(1'b1, 32'h0100_0005, 8'hA5);
    step();
    spi_idle();
    chk("ramw_we", ram_we_o, 1);
    chk("ramw_addr", ram_addr_o, 7'h05);
    chk("ramw_din", ram_din_o, 8'hA5);
    step();
    chk("ramw_ack", spi_ack_o, 1);
    chk("ramw_we_off", ram_we_o, 0);
    go_phase(0);
    spi_req(1'b0, 32'h0100_0005, 8'h00);
    step();
    spi_idle();
    chk("ramr_we", ram_we_o, 0);
    chk("ramr_addr", ram_addr_o, 7'h05);
    step();
    chk("ramr_ack", spi_ack_o, 1);
    chk("ramr_data", spi_data_o, 8'hA5);
    step();
    chk("ramr_ack_off", spi_ack_o, 0);
    chk("ramr_hold", spi_data_o, 8'hA5);

    // CPU write 0x3C to 0x0081: only at phase 15
    go_phase(0);
    cpu_addr_i = 16'h0081; cpu_dout_i = 8'h3C; cpu_rnw_i = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("cpu_we", ram_we_o, (ph == 15));
      if (ph == 15) begin
        chk("cpu_addr", ram_addr_o, 7'h01);
        chk("cpu_din", ram_din_o, 8'h3C);
      end
      step();
    end
    // PIA decode: no write
    cpu_addr_i = 16'h0281;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (ram_we_o) cnt++;
      step();
    end
    chk("pia_no_we", cnt, 0);
    cpu_rnw_i = 1'b1; cpu_addr_i = 16'h0000;
    stall_i = 1'b1;
    #1;
    chk("stall_rdy", cpu_rdy_o, 0);
    stall_i = 1'b0;

    // control write 0x03: reset + halt from phase 2
    go_phase(0);
    spi_req(1'b1, 32'hFF00_0000, 8'h03);
    step();
    spi_idle();
    chk("ctrl_p1", ctrl_o, 8'h00);
    chk("ctrl_p1_rdy", cpu_rdy_o, 1);
    step();
    chk("ctrl_p2", ctrl_o, 8'h03);
    chk("ctrl_reset", cpu_reset_o, 1);
    chk("ctrl_rdy", cpu_rdy_o, 0);
    chk("ctrl_ack", spi_ack_o, 1);
    cpu_addr_i = 16'h0080; cpu_dout_i = 8'h77; cpu_rnw_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (ram_we_o) cnt++;
      step();
    end
    chk("halt_no_we", cnt, 0);
    cpu_rnw_i = 1'b1; cpu_addr_i = 16'h0000;
    // control read
    go_phase(0);
    spi_req(1'b0, 32'hFF00_0000, 8'h00);
    step();
    spi_idle();
    step();
    chk("ctrl_rd_ack", spi_ack_o, 1);
    chk("ctrl_rd_data", spi_data_o, 8'h03);
    // release
    go_phase(0);
    spi_req(1'b1, 32'hFF00_0000, 8'h00);
    step();
    spi_idle();
    step();
    chk("ctrl_clr", ctrl_o, 8'h00);
    chk("ctrl_clr_rdy", cpu_rdy_o, 1);

    // ROM write and unmapped read
    go_phase(0);
    spi_req(1'b1, 32'h0000_0FFF, 8'h4C);
    step();
    spi_idle();
    chk("rom_we", rom_we_o, 1);
    chk("rom_addr", rom_addr_o, 12'hFFF);
    chk("rom_din", rom_din_o, 8'h4C);
    chk("rom_no_ram", ram_we_o, 0);
    step();
    chk("rom_we_off", rom_we_o, 0);
    chk("rom_ack", spi_ack_o, 1);
    go_phase(0);
    spi_req(1'b0, 32'h1200_0000, 8'h00);
    step();
    spi_idle();
    chk("unm_rom_we", rom_we_o, 0);
    chk("unm_ram_we", ram_we_o, 0);
    step();
    chk("unm_ack", spi_ack_o, 1);
    chk("unm_data", spi_data_o, 8'h00);

    // overflow: strobes at phases 3 and 5
    go_phase(3);
    spi_req(1'b1, 32'h0100_0010, 8'h11);
    step();
    spi_idle();
    chk("ovf_first", spi_ovf_o, 0);
    go_phase(5);
    spi_req(1'b1, 32'h0100_0011, 8'h22);
    step();
    spi_idle();
    chk("ovf_set", spi_ovf_o, 1);
    go_phase(1);
    chk("ovf_we", ram_we_o, 1);
    chk("ovf_addr", ram_addr_o, 7'h10);
    chk("ovf_din", ram_din_o, 8'h11);
    step();
    chk("ovf_ack", spi_ack_o, 1);
    step();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (spi_ack_o) cnt++;
      step();
    end
    chk("ovf_single_ack", cnt, 0);

    // strobe coincident with phase-1 service is accepted
    go_phase(0);
    spi_req(1'b1, 32'h0100_0020, 8'h33);
    step();
    spi_req(1'b1, 32'h0100_0021, 8'h44);
    chk("coin_addr_a", ram_addr_o, 7'h20);
    chk("coin_din_a", ram_din_o, 8'h33);
    step();
    spi_idle();
    chk("coin_ack_a", spi_ack_o, 1);
    go_phase(1);
    chk("coin_we_b", ram_we_o, 1);
    chk("coin_addr_b", ram_addr_o, 7'h21);
    chk("coin_din_b", ram_din_o, 8'h44);
    step();
    chk("coin_ack_b", spi_ack_o, 1);
    chk("ovf_sticky", spi_ovf_o, 1);

    // reset during service aborts the request
    go_phase(0);
    spi_req(1'b1, 32'h0100_0030, 8'h55);
    step();
    spi_idle();
    rst_i = 1'b1;
    #1;
    chk("abort_we", ram_we_o, 0);
    @(posedge clk_i);
    #1;
    ph = 0;
    chk("abort_ack", spi_ack_o, 0);
    chk("abort_ovf", spi_ovf_o, 0);
    rst_i = 1'b0;
    step();
    chk("abort_no_svc", ram_we_o, 0);
    step();
    chk("abort_no_ack", spi_ack_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
